// File: rtl/hubris_runctl_pkg.sv
// Shared definitions for the Hubris run controller.
//   run_state_e    : run sequencer FSM states
//   DUMP_KIND_*    : dump_kind encodings carried on each streamed beat
package hubris_runctl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRst,
      StRun,
      StDPc,
      StDReg,
      StDMem,
      StDone
   } run_state_e;

   localparam logic [1:0] DUMP_KIND_PC  = 2'd0;
   localparam logic [1:0] DUMP_KIND_REG = 2'd1;
   localparam logic [1:0] DUMP_KIND_MEM = 2'd2;

endpackage

// File: rtl/hubris_run_controller_if.sv
// Dump stream interface: one beat per valid && ready.
//   valid/ready : handshake (master drives valid, slave drives ready)
//   data        : beat payload
//   kind        : DUMP_KIND_PC/REG/MEM
//   index       : register number or memory word address (0 for PC)
//   last        : final beat of the dump
interface hubris_run_controller_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = 10
);
   logic                  valid;
   logic                  ready;
   logic [DATA_WIDTH-1:0] data;
   logic [1:0]            kind;
   logic [IDX_WIDTH-1:0]  index;
   logic                  last;

   modport master (output valid, data, kind, index, last, input ready);
   modport slave  (input valid, data, kind, index, last, output ready);
endinterface

// File: rtl/hubris_dump_streamer.sv
// One-entry output register for the dump stream. Holds a beat stable until it retires.
//   clk_i, rst_i    : clock, asynchronous active-high reset
//   load_i          : capture a new beat (only when can_load_o)
//   data_i..last_i  : beat fields to capture
//   can_load_o      : slot empty, or occupied and retiring this cycle
//   retire_last_o   : the beat retiring this cycle carries last
//   dump            : stream master port
module hubris_dump_streamer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = 10
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    load_i,
   input  logic [DATA_WIDTH-1:0]   data_i,
   input  logic [1:0]              kind_i,
   input  logic [IDX_WIDTH-1:0]    index_i,
   input  logic                    last_i,
   output logic                    can_load_o,
   output logic                    retire_last_o,
   hubris_run_controller_if.master dump
);
   logic                  valid_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [1:0]            kind_q;
   logic [IDX_WIDTH-1:0]  index_q;
   logic                  last_q;
   logic                  retire;

   assign retire        = valid_q && dump.ready;
   assign can_load_o    = !valid_q || dump.ready;
   assign retire_last_o = retire && last_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         kind_q  <= '0;
         index_q <= '0;
         last_q  <= 1'b0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         kind_q  <= kind_i;
         index_q <= index_i;
         last_q  <= last_i;
      end else if (retire) begin
         valid_q <= 1'b0;
      end
   end

   assign dump.valid = valid_q;
   assign dump.data  = data_q;
   assign dump.kind  = kind_q;
   assign dump.index = index_q;
   assign dump.last  = last_q;
endmodule

// File: rtl/hubris_run_controller.sv
// Run sequencer for one Hubris core: pulses core reset, runs until halt or cycle limit,
// then streams PC, register file and (optionally) data memory.
// Build option: define HUBRIS_RUNCTL_MEMDUMP_EN to include the data-memory dump phase.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   start_i             : begin a run (honoured in IDLE or DONE only)
//   core_reset_o        : reset to the core
//   core_halt_i/pc_i    : core halt flag and pc
//   reg_rd_addr_o/data_i: combinational register-file read
//   mem_rd_en_o/addr_o  : data-memory read, data on mem_rd_data_i one cycle later
//   dump                : dump stream master port
//   busy_o/done_o/timeout_o/cycle_count_o : status
module hubris_run_controller
   import hubris_runctl_pkg::*;
#(
   parameter int unsigned RESET_CYCLES   = 4,
   parameter int unsigned CYCLE_LIMIT    = 1000000,
   parameter int unsigned CNT_WIDTH      = 32,
   parameter int unsigned REG_NUMBER     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned MEM_ADDR_WIDTH = 10,
   localparam int unsigned REG_AW = (REG_NUMBER > 1) ? $clog2(REG_NUMBER) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   output logic                      core_reset_o,
   input  logic                      core_halt_i,
   input  logic [DATA_WIDTH-1:0]     core_pc_i,
   output logic [REG_AW-1:0]         reg_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]     reg_rd_data_i,
   output logic                      mem_rd_en_o,
   output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr_o,
   input  logic [DATA_WIDTH-1:0]     mem_rd_data_i,
   hubris_run_controller_if.master   dump,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      timeout_o,
   output logic [CNT_WIDTH-1:0]      cycle_count_o
);
   localparam int unsigned RST_CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

   run_state_e                state_q, state_d;
   logic [RST_CW-1:0]         rst_cnt_q, rst_cnt_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic                      timeout_q, timeout_d;
   logic [DATA_WIDTH-1:0]     pc_q, pc_d;
   logic [REG_AW-1:0]         reg_idx_q, reg_idx_d;
   logic [MEM_ADDR_WIDTH-1:0] mem_idx_q, mem_idx_d;
   logic                      mem_pend_q, mem_pend_d;  // read issued, data arrives this cycle
   logic                      tail_q, tail_d;          // final beat already handed to streamer

   logic                      ld;
   logic [DATA_WIDTH-1:0]     ld_data;
   logic [1:0]                ld_kind;
   logic [MEM_ADDR_WIDTH-1:0] ld_idx;
   logic                      ld_last;
   logic                      can_load;
   logic                      retire_last;
   logic                      mem_rd_en;

`ifndef HUBRIS_RUNCTL_MEMDUMP_EN
   logic unused_mem_rd_data;
   assign unused_mem_rd_data = ^mem_rd_data_i;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         rst_cnt_q  <= '0;
         cnt_q      <= '0;
         timeout_q  <= 1'b0;
         pc_q       <= '0;
         reg_idx_q  <= '0;
         mem_idx_q  <= '0;
         mem_pend_q <= 1'b0;
         tail_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rst_cnt_q  <= rst_cnt_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
         pc_q       <= pc_d;
         reg_idx_q  <= reg_idx_d;
         mem_idx_q  <= mem_idx_d;
         mem_pend_q <= mem_pend_d;
         tail_q     <= tail_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rst_cnt_d  = rst_cnt_q;
      cnt_d      = cnt_q;
      timeout_d  = timeout_q;
      pc_d       = pc_q;
      reg_idx_d  = reg_idx_q;
      mem_idx_d  = mem_idx_q;
      mem_pend_d = mem_pend_q;
      tail_d     = tail_q;
      ld         = 1'b0;
      ld_data    = '0;
      ld_kind    = DUMP_KIND_PC;
      ld_idx     = '0;
      ld_last    = 1'b0;
      mem_rd_en  = 1'b0;

      case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               state_d    = StRst;
               rst_cnt_d  = '0;
               cnt_d      = '0;
               timeout_d  = 1'b0;
               reg_idx_d  = '0;
               mem_idx_d  = '0;
               mem_pend_d = 1'b0;
               tail_d     = 1'b0;
            end
         end
         StRst: begin
            if (rst_cnt_q == RST_CW'(RESET_CYCLES - 1)) state_d = StRun;
            else rst_cnt_d = rst_cnt_q + 1'b1;
         end
         StRun: begin
            if (core_halt_i) begin
               state_d = StDPc;
               pc_d    = core_pc_i;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_WIDTH'(CYCLE_LIMIT - 1)) begin
                  timeout_d = 1'b1;
                  state_d   = StDPc;
                  pc_d      = core_pc_i;
               end
            end
         end
         StDPc: begin
            if (can_load) begin
               ld      = 1'b1;
               ld_data = pc_q;
               state_d = StDReg;
            end
         end
         StDReg: begin
            if (!tail_q && can_load) begin
               ld      = 1'b1;
               ld_data = reg_rd_data_i;
               ld_kind = DUMP_KIND_REG;
               ld_idx  = MEM_ADDR_WIDTH'(reg_idx_q);
               if (reg_idx_q == REG_AW'(REG_NUMBER - 1)) begin
`ifdef HUBRIS_RUNCTL_MEMDUMP_EN
                  state_d = StDMem;
`else
                  ld_last = 1'b1;
                  tail_d  = 1'b1;
`endif
               end else begin
                  reg_idx_d = reg_idx_q + 1'b1;
               end
            end
         end
`ifdef HUBRIS_RUNCTL_MEMDUMP_EN
         StDMem: begin
            if (!tail_q) begin
               if (!mem_pend_q) begin
                  // The slot is free next cycle whenever it can load now, so the
                  // returning word always lands without a holding register.
                  if (can_load) begin
                     mem_rd_en  = 1'b1;
                     mem_pend_d = 1'b1;
                  end
               end else begin
                  ld         = 1'b1;
                  ld_data    = mem_rd_data_i;
                  ld_kind    = DUMP_KIND_MEM;
                  ld_idx     = mem_idx_q;
                  ld_last    = (mem_idx_q == {MEM_ADDR_WIDTH{1'b1}});
                  mem_pend_d = 1'b0;
                  if (ld_last) tail_d = 1'b1;
                  else mem_idx_d = mem_idx_q + 1'b1;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase

      if (retire_last) state_d = StDone;
   end

   hubris_dump_streamer #(
      .DATA_WIDTH(DATA_WIDTH),
      .IDX_WIDTH (MEM_ADDR_WIDTH)
   ) u_streamer (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .load_i       (ld),
      .data_i       (ld_data),
      .kind_i       (ld_kind),
      .index_i      (ld_idx),
      .last_i       (ld_last),
      .can_load_o   (can_load),
      .retire_last_o(retire_last),
      .dump         (dump)
   );

   assign core_reset_o  = (state_q == StIdle) || (state_q == StRst);
   assign busy_o        = (state_q != StIdle) && (state_q != StDone);
   assign done_o        = (state_q == StDone);
   assign timeout_o     = timeout_q;
   assign cycle_count_o = cnt_q;
   assign reg_rd_addr_o = reg_idx_q;
   assign mem_rd_addr_o = mem_idx_q;
   assign mem_rd_en_o   = mem_rd_en;
endmodule

// File: tb/tb_hubris_run_controller.sv
// Self-checking bench for hubris_run_controller: directed runs with randomized data and
// ready stalls, checked against a beat-list model built from the expected dump order.
module tb_hubris_run_controller;
   localparam int unsigned RC  = 4;
   localparam int unsigned LIM = 100;
   localparam int unsigned NR  = 4;
   localparam int unsigned DW  = 32;
   localparam int unsigned MAW = 3;
   localparam int unsigned NM  = 1 << MAW;
`ifdef HUBRIS_RUNCTL_MEMDUMP_EN
   localparam bit MEM_EN = 1'b1;
`else
   localparam bit MEM_EN = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic           core_reset;
   logic           core_halt = 1'b0;
   logic [DW-1:0]  core_pc = '0;
   logic [1:0]     reg_rd_addr;
   logic [DW-1:0]  reg_rd_data;
   logic           mem_rd_en;
   logic [MAW-1:0] mem_rd_addr;
   logic [DW-1:0]  mem_rd_data = '0;
   logic           busy, done, timeout;
   logic [31:0]    cycle_count;

   logic [DW-1:0]  regs[NR];
   logic [DW-1:0]  mem[NM];

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hubris_run_controller_if #(.DATA_WIDTH(DW), .IDX_WIDTH(MAW)) dif ();

   hubris_run_controller #(
      .RESET_CYCLES  (RC),
      .CYCLE_LIMIT   (LIM),
      .CNT_WIDTH     (32),
      .REG_NUMBER    (NR),
      .DATA_WIDTH    (DW),
      .MEM_ADDR_WIDTH(MAW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .start_i      (start),
      .core_reset_o (core_reset),
      .core_halt_i  (core_halt),
      .core_pc_i    (core_pc),
      .reg_rd_addr_o(reg_rd_addr),
      .reg_rd_data_i(reg_rd_data),
      .mem_rd_en_o  (mem_rd_en),
      .mem_rd_addr_o(mem_rd_addr),
      .mem_rd_data_i(mem_rd_data),
      .dump         (dif),
      .busy_o       (busy),
      .done_o       (done),
      .timeout_o    (timeout),
      .cycle_count_o(cycle_count)
   );

   // Core-side models: combinational regfile, 1-cycle memory returning junk when not read.
   assign reg_rd_data = regs[reg_rd_addr];
   always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : $urandom;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic randomize_core();
      core_pc = $urandom;
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      for (int i = 0; i < NM; i++) mem[i] = $urandom;
   endtask

   // Beat model in dump order: {kind, index, last, data}.
   function automatic logic [63:0] exp_beat(input int b);
      int nb;
      logic [1:0]     k;
      logic [MAW-1:0] ix;
      logic [DW-1:0]  d;
      nb = 1 + NR + (MEM_EN ? NM : 0);
      if (b == 0) begin
         k = 2'd0; ix = '0; d = core_pc;
      end else if (b <= NR) begin
         k = 2'd1; ix = MAW'(b - 1); d = regs[b - 1];
      end else begin
         k = 2'd2; ix = MAW'(b - 1 - NR); d = mem[b - 1 - NR];
      end
      return {26'd0, k, ix, (b == nb - 1), d};
   endfunction

   // Pulse start from IDLE/DONE and count the cycles the core is held in reset.
   task automatic do_start();
      int rc;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 64'(busy), 64'd1);
      chk("start_count_clr", 64'(cycle_count), 64'd0);
      chk("start_timeout_clr", 64'(timeout), 64'd0);
      rc = 0;
      while (core_reset && rc < 50) begin
         rc++;
         @(negedge clk);
      end
      chk("reset_cycles", 64'(rc), 64'(RC));
   endtask

   // Collect the dump with optional random ready, checking every retired beat.
   task automatic collect(input bit rand_ready);
      int  nb, bi, guard;
      bit  stalled, mem_seen, got_last;
      logic [63:0] held, cur;
      nb = 1 + NR + (MEM_EN ? NM : 0);
      bi = 0; guard = 0; stalled = 0; mem_seen = 0; got_last = 0; held = '0;
      while (!got_last && guard < 2000) begin
         guard++;
         dif.ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (mem_rd_en) mem_seen = 1'b1;
         cur = {26'd0, dif.kind, dif.index, dif.last, dif.data};
         if (stalled) begin
            chk("stall_valid", 64'(dif.valid), 64'd1);
            chk("stall_stable", cur, held);
         end
         if (dif.valid && dif.ready) begin
            chk($sformatf("beat%0d", bi), cur, exp_beat(bi));
            bi++;
            if (dif.last || bi >= nb) got_last = 1'b1;
         end
         stalled = dif.valid && !dif.ready;
         held = cur;
         @(negedge clk);
      end
      chk("dump_finished", 64'(got_last), 64'd1);
      chk("beat_count", 64'(bi), 64'(nb));
      if (!MEM_EN) chk("mem_rd_en_never", 64'(mem_seen), 64'd0);
      chk("after_dump_valid", 64'(dif.valid), 64'd0);
   endtask

   // Full run; halt_at < 0 means the core never halts.
   task automatic do_run(input int halt_at, input bit rand_ready);
      int c0;
      int exp_cnt;
      bit exp_to;
      randomize_core();
      do_start();
      if (halt_at >= 0) begin
         repeat (halt_at) @(negedge clk);
         core_halt = 1'b1;
         @(negedge clk);
         core_halt = 1'b0;
         exp_cnt = (halt_at >= int'(LIM)) ? int'(LIM) : halt_at;
         exp_to  = (halt_at >= int'(LIM));
      end else begin
         repeat (10) @(negedge clk);
         c0 = int'(cycle_count);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk("start_in_run_ignored", 64'(cycle_count), 64'(c0 + 1));
         chk("start_in_run_busy", 64'(busy), 64'd1);
         exp_cnt = int'(LIM);
         exp_to  = 1'b1;
      end
      collect(rand_ready);
      chk("done", 64'(done), 64'd1);
      chk("done_busy", 64'(busy), 64'd0);
      chk("done_core_reset", 64'(core_reset), 64'd0);
      chk("cycle_count", 64'(cycle_count), 64'(exp_cnt));
      chk("timeout", 64'(timeout), 64'(exp_to));
   endtask

   initial begin
      int guard;
      dif.ready = 1'b1;
      for (int i = 0; i < NR; i++) regs[i] = '0;
      for (int i = 0; i < NM; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_core_reset", 64'(core_reset), 64'd1);
      chk("rst_valid", 64'(dif.valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_timeout", 64'(timeout), 64'd0);
      chk("rst_count", 64'(cycle_count), 64'd0);
      chk("rst_mem_rd_en", 64'(mem_rd_en), 64'd0);
      chk("rst_addrs", 64'({reg_rd_addr, mem_rd_addr}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_core_reset", 64'(core_reset), 64'd1);

      do_run(20, 1'b0);                      // halt after 20 RUN cycles, ready always high
      do_run(-1, 1'b1);                      // never halts: timeout, start mid-run ignored
      do_run(0, 1'b1);                       // halt in first RUN cycle
      do_run(int'($urandom_range(1, 99)), 1'b1);
      do_run(int'($urandom_range(1, 99)), 1'b1);

      // Asynchronous reset in the middle of the register dump.
      randomize_core();
      do_start();
      repeat (2) @(negedge clk);
      core_halt = 1'b1;
      @(negedge clk);
      core_halt = 1'b0;
      dif.ready = 1'b1;
      guard = 0;
      while (!(dif.valid && dif.kind == 2'd1 && dif.index == MAW'(1)) && guard < 50) begin
         guard++;
         @(negedge clk);
      end
      chk("reached_dreg", 64'(guard < 50), 64'd1);
      chk("mid_dreg_no_last", 64'(dif.last), 64'd0);
      rst = 1'b1;
      #1;
      chk("abort_valid", 64'(dif.valid), 64'd0);
      chk("abort_core_reset", 64'(core_reset), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_count", 64'(cycle_count), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_run(int'($urandom_range(1, 50)), 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
